debounce_sync: RTL and testbench

Input conditioning stage that sits directly upstream of the team's D flip-flops. It takes a raw asynchronous level, such as a push-button, switch or off-board strobe, and synchronises it into the `clk` domain. It then debounces the level with a programmable cycle-count filter and drives a clean registered level plus single-cycle rise/fall pulses, which downstream flops use as `d` or as an enable.

---
 rtl/debounce_pkg.sv | 28 ++
 rtl/sync2.sv | 26 ++
 rtl/debounce_sync.sv | 118 +++++++++++
 tb/tb_debounce_sync.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared encodings and the DEBOUNCE legality check for the debounce_sync input stage.
`ifndef DEBOUNCE_PKG_SV
`define DEBOUNCE_PKG_SV

`define DEBOUNCE_RANGE_CHECK(D, W) \
  if (!debounce_pkg::debounce_in_range(D, W)) begin : g_debounce_range_err \
    $error("debounce_sync: DEBOUNCE=%0d outside legal range 1..2^%0d-1", D, W); \
  end

package debounce_pkg;

  typedef enum logic [1:0] {
    ST_LO  = 2'b00,
    CHK_HI = 2'b01,
    ST_HI  = 2'b10,
    CHK_LO = 2'b11
  } state_e;

  // 64-bit arithmetic so wide counters cannot overflow the limit computation
  function automatic bit debounce_in_range(input int unsigned d, input int unsigned w);
    logic [63:0] lim;
    lim = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    return (d >= 1) && (64'(d) <= lim);
  endfunction

endpackage

`endif

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level; q is safe to use in the clk domain.
module sync2 #(
  parameter bit RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1;
  logic s2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= RESET_LEVEL;
      s2 <= RESET_LEVEL;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/debounce_sync.sv
// Synchronise a raw level, qualify changes over DEBOUNCE enabled samples, and drive a
// clean registered level with one-cycle rise/fall pulses.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE    = 16,
  parameter int unsigned CNT_W       = 8,
  parameter bit          RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  input  logic en,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  `DEBOUNCE_RANGE_CHECK(DEBOUNCE, CNT_W)

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE - 1);
  localparam state_e           RESET_STATE = RESET_LEVEL ? ST_HI : ST_LO;

  logic             s2;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;

  sync2 #(.RESET_LEVEL(RESET_LEVEL)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (din),
    .q     (s2)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      dout_q  <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  // A level mismatch always wins over the count, so a bounce aborts even with en low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      ST_LO: begin
        if (s2) begin
          state_d = CHK_HI;
          cnt_d   = '0;
        end
      end
      CHK_HI: begin
        if (!s2) begin
          state_d = ST_LO;
          cnt_d   = '0;
        end else if (en) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_HI;
            cnt_d   = '0;
            dout_d  = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_HI: begin
        if (!s2) begin
          state_d = CHK_LO;
          cnt_d   = '0;
        end
      end
      CHK_LO: begin
        if (s2) begin
          state_d = ST_HI;
          cnt_d   = '0;
        end else if (en) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_LO;
            cnt_d   = '0;
            dout_d  = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = RESET_STATE;
    endcase
    busy_d = (state_d == CHK_HI) || (state_d == CHK_LO);
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: vector table, hand-written corner sequences, and a randomized
// run against a history-based reference model. Two instances cover both reset levels.
module tb_debounce_sync;

  localparam int unsigned DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din0 = 1'b0, en0 = 1'b1;
  logic din1 = 1'b1, en1 = 1'b1;
  logic dout0, rise0, fall0, busy0;
  logic dout1, rise1, fall1, busy1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic din;
    logic en;
    logic dout;
    logic rise;
    logic fall;
    logic busy;
  } vec_t;

  vec_t vecs[$];

  // reference model state: synchroniser pipe, accepted level, enabled samples of the open run
  logic m_s1, m_s2, m_dout, s2_seen;
  bit   in_run;
  bit   run_en[$];
  logic e_rise, e_fall;
  int   hold, n_en;

  debounce_sync #(.DEBOUNCE(DB), .CNT_W(8), .RESET_LEVEL(1'b0)) u0 (
    .clk(clk), .reset(rst), .din(din0), .en(en0),
    .dout(dout0), .rise(rise0), .fall(fall0), .busy(busy0)
  );

  debounce_sync #(.DEBOUNCE(DB), .CNT_W(8), .RESET_LEVEL(1'b1)) u1 (
    .clk(clk), .reset(rst), .din(din1), .en(en1),
    .dout(dout1), .rise(rise1), .fall(fall1), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic d, input logic e, input logic [3:0] o);
    vec_t v;
    v = {d, e, o};
    return v;
  endfunction

  initial begin
    // outputs {dout, rise, fall, busy} after each edge
    // clean rise: busy from E3, dout/rise at E7
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(1'b1, 1'b1, (i == 7) ? 4'b1100 : (i == 8) ? 4'b1000 :
                                    (i >= 3) ? 4'b0001 : 4'b0000));
    // clean fall back to 0
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(1'b0, 1'b1, (i == 7) ? 4'b0010 : (i == 8) ? 4'b0000 :
                                    (i >= 3) ? 4'b1001 : 4'b1000));
    // two-cycle glitch: busy for two cycles, no rise
    for (int i = 1; i <= 6; i++)
      vecs.push_back(mk((i <= 2) ? 1'b1 : 1'b0, 1'b1,
                        (i == 3 || i == 4) ? 4'b0001 : 4'b0000));

    // asynchronous reset assertion, before any clk edge
    #2 rst = 1'b0;
    #1;
    chk("rst_dout0", dout0, 1'b0);
    chk("rst_rise0", rise0, 1'b0);
    chk("rst_fall0", fall0, 1'b0);
    chk("rst_busy0", busy0, 1'b0);
    chk("rst_dout1", dout1, 1'b1);
    chk("rst_rise1", rise1, 1'b0);
    repeat (2) tick();
    rst = 1'b1;

    foreach (vecs[k]) begin
      din0 = vecs[k].din;
      en0  = vecs[k].en;
      tick();
      chk($sformatf("vec%0d_dout", k), dout0, vecs[k].dout);
      chk($sformatf("vec%0d_rise", k), rise0, vecs[k].rise);
      chk($sformatf("vec%0d_fall", k), fall0, vecs[k].fall);
      chk($sformatf("vec%0d_busy", k), busy0, vecs[k].busy);
    end

    // en every 4th cycle: CHK_HI entry at E3, enabled samples E4,E8,E12,E16
    din0 = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      en0 = ((i % 4) == 0);
      tick();
      chk($sformatf("gate_dout%0d", i), dout0, (i >= 16));
      chk($sformatf("gate_rise%0d", i), rise0, (i == 16));
      chk($sformatf("gate_busy%0d", i), busy0, (i >= 3 && i < 16));
    end

    // mid-cycle reset with din=1 while dout and rise are high
    en0 = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_dout", dout0, 1'b0);
    chk("mid_rst_rise", rise0, 1'b0);
    chk("mid_rst_fall", fall0, 1'b0);
    chk("mid_rst_busy", busy0, 1'b0);
    tick();
    chk("mid_rst_hold_dout", dout0, 1'b0);
    rst = 1'b1;
    repeat (8) tick();
    chk("rehigh_dout", dout0, 1'b1);

    // fall aborted by reset two cycles into CHK_LO
    din0 = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("abort_fall%0d", i), fall0, 1'b0);
      chk($sformatf("abort_busy%0d", i), busy0, (i >= 3));
      chk($sformatf("abort_dout%0d", i), dout0, 1'b1);
    end
    #2 rst = 1'b0;
    #1;
    chk("abort_rst_dout", dout0, 1'b0);
    chk("abort_rst_busy", busy0, 1'b0);
    chk("abort_rst_fall", fall0, 1'b0);
    tick();
    rst = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("post_abort_fall%0d", i), fall0, 1'b0);
      chk($sformatf("post_abort_rise%0d", i), rise0, 1'b0);
      chk($sformatf("post_abort_dout%0d", i), dout0, 1'b0);
    end

    // randomized bursts against the reference model; u0 is settled low here
    m_s1 = 1'b0; m_s2 = 1'b0; m_dout = 1'b0; in_run = 1'b0; run_en.delete();
    hold = 0;
    for (int c = 0; c < 600; c++) begin
      if (hold == 0) begin
        din0 = 1'($urandom_range(0, 1));
        hold = int'($urandom_range(1, 9));
      end
      hold--;
      en0 = ($urandom_range(0, 9) < 7);
      tick();
      s2_seen = m_s2;
      m_s2 = m_s1;
      m_s1 = din0;
      e_rise = 1'b0;
      e_fall = 1'b0;
      if (s2_seen == m_dout) begin
        in_run = 1'b0;
        run_en.delete();
      end else if (!in_run) begin
        in_run = 1'b1;
        run_en.delete();
      end else begin
        run_en.push_back(en0);
        n_en = 0;
        foreach (run_en[k]) n_en += int'(run_en[k]);
        if (n_en == int'(DB)) begin
          m_dout = s2_seen;
          e_rise = s2_seen;
          e_fall = ~s2_seen;
          in_run = 1'b0;
          run_en.delete();
        end
      end
      chk($sformatf("rnd%0d_dout", c), dout0, m_dout);
      chk($sformatf("rnd%0d_rise", c), rise0, e_rise);
      chk($sformatf("rnd%0d_fall", c), fall0, e_fall);
      chk($sformatf("rnd%0d_busy", c), busy0, 1'(in_run));
    end

    // RESET_LEVEL=1 instance: reset with din=1, then a held low
    din1 = 1'b1;
    en1  = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rl1_rst_dout", dout1, 1'b1);
    chk("rl1_rst_rise", rise1, 1'b0);
    chk("rl1_rst_busy", busy1, 1'b0);
    tick();
    rst = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("rl1_hold_dout%0d", i), dout1, 1'b1);
      chk($sformatf("rl1_hold_rise%0d", i), rise1, 1'b0);
    end
    din1 = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk($sformatf("rl1_dout%0d", i), dout1, (i < 7));
      chk($sformatf("rl1_fall%0d", i), fall1, (i == 7));
      chk($sformatf("rl1_rise%0d", i), rise1, 1'b0);
      chk($sformatf("rl1_busy%0d", i), busy1, (i >= 3 && i < 7));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
